round_controller: RTL and testbench
===================================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter COUNT_TICKS, default 20, game ticks per countdown digit.
REQ-002 SHALL have parameter ROUNDS_TO_WIN, default 2, round wins that end the match (range 1-3).
REQ-003 SHALL have parameter END_HOLD_TICKS, default 60, game ticks spent in ROUND_END.
REQ-004 SHALL have parameter HOLD_RESET_TICKS, default 40, game ticks start_btn must be held to abort the match.
REQ-005 SHALL have parameter ROUND_TIME_TICKS, default 1200, fight time limit in game ticks (used only with ROUND_TIMER_EN).
REQ-006 SHALL have port clk input 1, system clock; one clock only, all flops on its rising edge.
REQ-007 SHALL have port reset input 1, asynchronous, active-high.
REQ-008 SHALL have port game_tick input 1, one-clk-wide 20 Hz enable pulse.
REQ-009 SHALL have port start_btn input 1, debounced start/abort button.
REQ-010 SHALL have port round_result input 2, from health management: 00 none, 01 P1 KO win, 10 P2 KO win, 11 double KO.
REQ-011 SHALL have ports health_1, health_2 input 9 each, current player health.
REQ-012 SHALL have port round_reset output 1, held reset to physics/health blocks.
REQ-013 SHALL have port input_enable output 1, gates player movement handlers.
REQ-014 SHALL have port state output 3: 0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_END.
REQ-015 SHALL have ports p1_rounds, p2_rounds output 2 each, round wins this match.
REQ-016 SHALL have port countdown output 2, digit shown during COUNTDOWN (3,2,1), else 0.
REQ-017 SHALL have port match_winner output 2: 00 none, 01 P1, 10 P2.

Function
REQ-018 SHALL update state, counters and scores only on clk edges where game_tick=1; outputs are registered.
REQ-019 IDLE: start_btn=1 on a tick -> COUNTDOWN, scores cleared, countdown=3.
REQ-020 COUNTDOWN: countdown decrements every COUNT_TICKS ticks; after the "1" digit expires -> FIGHT (3*COUNT_TICKS ticks total).
REQ-021 round_reset SHALL be 1 in IDLE and COUNTDOWN, 0 otherwise; input_enable SHALL be 1 only in FIGHT.
REQ-022 FIGHT: round_result 01 -> p1_rounds+1, 10 -> p2_rounds+1, 11 -> no score; all -> ROUND_END on same tick.
REQ-023 round_result SHALL be ignored outside FIGHT.
REQ-024 ROUND_END: after END_HOLD_TICKS ticks -> MATCH_END if either score equals ROUNDS_TO_WIN, else COUNTDOWN (scores kept, countdown=3).
REQ-025 MATCH_END: match_winner set to scoring player on entry; start_btn on a tick -> IDLE, match_winner cleared.
REQ-026 Score counters SHALL saturate at ROUNDS_TO_WIN; never wrap.
REQ-027 Abort: start_btn held HOLD_RESET_TICKS consecutive ticks in any state except IDLE -> IDLE, scores and match_winner cleared; hold counter clears when start_btn=0 on a tick; abort outranks all other transitions.
REQ-028 Start press used to leave IDLE/MATCH_END SHALL NOT count toward abort (hold counter cleared on those transitions).

Reset
REQ-029 Reset SHALL force state=IDLE, round_reset=1, input_enable=0, countdown=0, p1_rounds=p2_rounds=0, match_winner=0, all internal counters 0, asynchronously.
REQ-030 Reset mid-FIGHT SHALL discard the round in progress; no score change after release.

Configuration
REQ-031 Macro ROUND_TIMER_EN defined: FIGHT tick counter; at ROUND_TIME_TICKS with round_result=00 -> higher health scores, equal health scores nobody, -> ROUND_END; KO on the timeout tick outranks timeout.
REQ-032 Macro ROUND_TIMER_EN undefined: no timer logic; FIGHT exits only on KO or abort; health_1/health_2 unused.

Verification
REQ-033 Reset, tick start_btn once -> COUNTDOWN, countdown 3/2/1 each 20 ticks, FIGHT at tick 60, input_enable=1, round_reset=0.
REQ-034 In FIGHT drive round_result=01 twice over two rounds -> p1_rounds=2, MATCH_END after 60 ticks, match_winner=01.
REQ-035 round_result=11 in FIGHT -> scores unchanged, ROUND_END then COUNTDOWN; round_result=10 during COUNTDOWN -> ignored.
REQ-036 Hold start_btn 39 ticks in FIGHT then release -> stays FIGHT; hold 40 ticks -> IDLE, scores 0.
REQ-037 ROUND_TIMER_EN, health_1=100, health_2=80, no KO -> after 1200 FIGHT ticks p1_rounds+1; KO 10 on tick 1200 -> p2 scores instead.
REQ-038 Assert reset mid-COUNTDOWN with p2_rounds=1 -> immediate IDLE, p2_rounds=0, round_reset=1.

Source files
------------

// File: rtl/round_controller.sv
// Round/match sequencer for a two-player fight game; optional fight time limit under ROUND_TIMER_EN.
// Latency: all outputs registered, updated on the clk edge that carries game_tick.
// Backpressure: none; inputs are sampled only on game_tick edges and never stalled.
module round_controller #(
    parameter int COUNT_TICKS      = 20,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int END_HOLD_TICKS   = 60,
    parameter int HOLD_RESET_TICKS = 40,
    parameter int ROUND_TIME_TICKS = 1200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_tick,
    input  logic       start_btn,
    input  logic [1:0] round_result,
    input  logic [8:0] health_1,
    input  logic [8:0] health_2,
    output logic       round_reset,
    output logic       input_enable,
    output logic [2:0] state,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] countdown,
    output logic [1:0] match_winner
);

    localparam int PH_MAX = (COUNT_TICKS > END_HOLD_TICKS) ? COUNT_TICKS : END_HOLD_TICKS;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int HW     = $clog2(HOLD_RESET_TICKS + 1);

    localparam logic [PW-1:0] CD_LAST   = PW'(COUNT_TICKS - 1);
    localparam logic [PW-1:0] END_LAST  = PW'(END_HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_RESET_TICKS - 1);
    localparam logic [1:0]    WIN       = 2'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4
    } state_t;

    state_t        st;
    logic [PW-1:0] phase_cnt;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    fight_result;

`ifdef ROUND_TIMER_EN
    localparam int            TW        = $clog2(ROUND_TIME_TICKS + 1);
    localparam logic [TW-1:0] TIME_LAST = TW'(ROUND_TIME_TICKS - 1);

    logic [TW-1:0] fight_cnt;
    logic          timeout;

    assign timeout = (fight_cnt == TIME_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fight_cnt <= '0;
        else if (st != S_FIGHT)
            fight_cnt <= '0;
        else if (game_tick)
            fight_cnt <= fight_cnt + 1'b1;
    end

    // A KO on the timeout tick wins; a timeout draw behaves like a double KO (no score).
    always_comb begin
        fight_result = round_result;
        if (round_result == 2'b00 && timeout) begin
            if (health_1 > health_2)
                fight_result = 2'b01;
            else if (health_2 > health_1)
                fight_result = 2'b10;
            else
                fight_result = 2'b11;
        end
    end
`else
    logic unused_health;
    assign unused_health = ^{health_1, health_2};
    assign fight_result  = round_result;
`endif

    assign state = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= S_IDLE;
            round_reset  <= 1'b1;
            input_enable <= 1'b0;
            countdown    <= 2'd0;
            p1_rounds    <= 2'd0;
            p2_rounds    <= 2'd0;
            match_winner <= 2'd0;
            phase_cnt    <= '0;
            hold_cnt     <= '0;
        end else if (game_tick) begin
            if (st != S_IDLE && start_btn && hold_cnt == HOLD_LAST) begin
                st           <= S_IDLE;
                round_reset  <= 1'b1;
                input_enable <= 1'b0;
                countdown    <= 2'd0;
                p1_rounds    <= 2'd0;
                p2_rounds    <= 2'd0;
                match_winner <= 2'd0;
                phase_cnt    <= '0;
                hold_cnt     <= '0;
            end else begin
                hold_cnt <= (st != S_IDLE && start_btn) ? hold_cnt + 1'b1 : '0;
                case (st)
                    S_IDLE: begin
                        if (start_btn) begin
                            st        <= S_COUNTDOWN;
                            countdown <= 2'd3;
                            p1_rounds <= 2'd0;
                            p2_rounds <= 2'd0;
                            phase_cnt <= '0;
                            hold_cnt  <= '0;
                        end
                    end
                    S_COUNTDOWN: begin
                        if (phase_cnt == CD_LAST) begin
                            phase_cnt <= '0;
                            if (countdown == 2'd1) begin
                                st           <= S_FIGHT;
                                countdown    <= 2'd0;
                                round_reset  <= 1'b0;
                                input_enable <= 1'b1;
                            end else begin
                                countdown <= countdown - 2'd1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    S_FIGHT: begin
                        if (fight_result != 2'b00) begin
                            st           <= S_ROUND_END;
                            input_enable <= 1'b0;
                            phase_cnt    <= '0;
                            if (fight_result == 2'b01 && p1_rounds != WIN)
                                p1_rounds <= p1_rounds + 2'd1;
                            if (fight_result == 2'b10 && p2_rounds != WIN)
                                p2_rounds <= p2_rounds + 2'd1;
                        end
                    end
                    S_ROUND_END: begin
                        if (phase_cnt == END_LAST) begin
                            phase_cnt <= '0;
                            if (p1_rounds == WIN) begin
                                st           <= S_MATCH_END;
                                match_winner <= 2'b01;
                            end else if (p2_rounds == WIN) begin
                                st           <= S_MATCH_END;
                                match_winner <= 2'b10;
                            end else begin
                                st          <= S_COUNTDOWN;
                                countdown   <= 2'd3;
                                round_reset <= 1'b1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    S_MATCH_END: begin
                        if (start_btn) begin
                            st           <= S_IDLE;
                            match_winner <= 2'd0;
                            round_reset  <= 1'b1;
                            hold_cnt     <= '0;
                        end
                    end
                    default: begin
                        st           <= S_IDLE;
                        round_reset  <= 1'b1;
                        input_enable <= 1'b0;
                        countdown    <= 2'd0;
                        phase_cnt    <= '0;
                        hold_cnt     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed scenarios plus randomized traffic against a phase/elapsed-tick model.
module tb_round_controller;

    localparam int CT = 20;
    localparam int RW = 2;
    localparam int EH = 60;
    localparam int HR = 40;
    localparam int RT = 1200;

    logic       clk = 1'b0;
    logic       reset;
    logic       game_tick;
    logic       start_btn;
    logic [1:0] round_result;
    logic [8:0] health_1;
    logic [8:0] health_2;
    logic       round_reset;
    logic       input_enable;
    logic [2:0] state;
    logic [1:0] p1_rounds;
    logic [1:0] p2_rounds;
    logic [1:0] countdown;
    logic [1:0] match_winner;

    int n_tests = 0;
    int n_fail  = 0;

    // model: phase (0..4), ticks elapsed in phase, scores, winner, start hold length
    int m_st, m_el, m_p1, m_p2, m_win, m_hold;

    round_controller #(
        .COUNT_TICKS(CT), .ROUNDS_TO_WIN(RW), .END_HOLD_TICKS(EH),
        .HOLD_RESET_TICKS(HR), .ROUND_TIME_TICKS(RT)
    ) dut (
        .clk(clk), .reset(reset), .game_tick(game_tick), .start_btn(start_btn),
        .round_result(round_result), .health_1(health_1), .health_2(health_2),
        .round_reset(round_reset), .input_enable(input_enable), .state(state),
        .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .countdown(countdown),
        .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    function void model_reset();
        m_st = 0; m_el = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_hold = 0;
    endfunction

    function void model_tick(input bit s, input logic [1:0] rr, input int h1, input int h2);
        int res;
        if (m_st != 0) begin
            m_hold = s ? m_hold + 1 : 0;
            if (m_hold == HR) begin
                model_reset();
                return;
            end
        end
        case (m_st)
            0: if (s) begin m_st = 1; m_el = 0; m_p1 = 0; m_p2 = 0; m_hold = 0; end
            1: begin
                m_el++;
                if (m_el == 3 * CT) begin m_st = 2; m_el = 0; end
            end
            2: begin
                m_el++;
                res = int'(rr);
`ifdef ROUND_TIMER_EN
                if (res == 0 && m_el == RT) res = (h1 > h2) ? 1 : (h2 > h1) ? 2 : 3;
`endif
                if (res != 0) begin
                    if (res == 1 && m_p1 < RW) m_p1++;
                    if (res == 2 && m_p2 < RW) m_p2++;
                    m_st = 3; m_el = 0;
                end
            end
            3: begin
                m_el++;
                if (m_el == EH) begin
                    m_el = 0;
                    if (m_p1 == RW) begin m_st = 4; m_win = 1; end
                    else if (m_p2 == RW) begin m_st = 4; m_win = 2; end
                    else m_st = 1;
                end
            end
            4: if (s) begin m_st = 0; m_win = 0; m_hold = 0; end
            default: model_reset();
        endcase
    endfunction

    function logic [12:0] model_outputs();
        int cd;
        cd = (m_st == 1) ? 3 - m_el / CT : 0;
        return {3'(m_st), 2'(m_p1), 2'(m_p2), 2'(cd), 2'(m_win), m_st <= 1, m_st == 2};
    endfunction

    task automatic step(input bit t, input bit s, input logic [1:0] rr);
        game_tick = t; start_btn = s; round_result = rr;
        @(posedge clk);
        if (t) model_tick(s, rr, int'(health_1), int'(health_2));
        @(negedge clk);
        game_tick = 1'b0; start_btn = 1'b0; round_result = 2'b00;
    endtask

    task automatic ticks(input int n, input bit s, input logic [1:0] rr);
        for (int i = 0; i < n; i++) step(1'b1, s, rr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if ({state, round_reset, input_enable, countdown, p1_rounds, p2_rounds, match_winner}
            !== {3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: st=%0d rr=%b ie=%b cd=%0d p1=%0d p2=%0d win=%0d, required 0,1,0,0,0,0,0",
                     state, round_reset, input_enable, countdown, p1_rounds, p2_rounds, match_winner);
        end
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 2'b01);
        n_tests++;
        if (state !== 3'd0 || p1_rounds !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_hold: st=%0d p1=%0d, required st=0 p1=0", state, p1_rounds);
        end
    endtask

    task automatic test_countdown();
        step(1'b1, 1'b1, 2'b00);
        n_tests++;
        if ({state, countdown, round_reset, input_enable} !== {3'd1, 2'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL countdown_entry: st=%0d cd=%0d rr=%b ie=%b, required 1,3,1,0",
                     state, countdown, round_reset, input_enable);
        end
        for (int i = 1; i <= 60; i++) begin
            if (i % 7 == 0) step(1'b0, 1'b1, 2'b11);
            step(1'b1, 1'b0, 2'b00);
            if (i == 19 || i == 20 || i == 40 || i == 59) begin
                n_tests++;
                if (state !== 3'd1 || countdown !== 2'(3 - i / 20)) begin
                    n_fail++;
                    $display("FAIL countdown_digit tick %0d: st=%0d cd=%0d, required st=1 cd=%0d",
                             i, state, countdown, 3 - i / 20);
                end
            end
        end
        n_tests++;
        if ({state, countdown, round_reset, input_enable} !== {3'd2, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fight_entry: st=%0d cd=%0d rr=%b ie=%b, required 2,0,0,1",
                     state, countdown, round_reset, input_enable);
        end
    endtask

    task automatic test_ko_match();
        step(1'b1, 1'b0, 2'b01);
        n_tests++;
        if (state !== 3'd3 || p1_rounds !== 2'd1 || input_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL ko_round1: st=%0d p1=%0d ie=%b, required 3,1,0", state, p1_rounds, input_enable);
        end
        ticks(59, 1'b0, 2'b00);
        n_tests++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL round_end_hold: st=%0d, required 3", state);
        end
        step(1'b1, 1'b0, 2'b00);
        n_tests++;
        if ({state, countdown, round_reset, p1_rounds} !== {3'd1, 2'd3, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL next_countdown: st=%0d cd=%0d rr=%b p1=%0d, required 1,3,1,1",
                     state, countdown, round_reset, p1_rounds);
        end
        ticks(60, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b01);
        ticks(59, 1'b0, 2'b00);
        n_tests++;
        if (state !== 3'd3 || p1_rounds !== 2'd2 || match_winner !== 2'd0) begin
            n_fail++;
            $display("FAIL ko_round2: st=%0d p1=%0d win=%0d, required 3,2,0", state, p1_rounds, match_winner);
        end
        step(1'b1, 1'b0, 2'b00);
        n_tests++;
        if ({state, match_winner, round_reset, input_enable} !== {3'd4, 2'b01, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL match_end: st=%0d win=%0d rr=%b ie=%b, required 4,1,0,0",
                     state, match_winner, round_reset, input_enable);
        end
        step(1'b1, 1'b1, 2'b00);
        n_tests++;
        if (state !== 3'd0 || match_winner !== 2'd0 || round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL match_exit: st=%0d win=%0d rr=%b, required 0,0,1", state, match_winner, round_reset);
        end
    endtask

    task automatic test_double_ko();
        step(1'b1, 1'b1, 2'b00);
        n_tests++;
        if (state !== 3'd1 || p1_rounds !== 2'd0) begin
            n_fail++;
            $display("FAIL restart_clears: st=%0d p1=%0d, required 1,0", state, p1_rounds);
        end
        ticks(60, 1'b0, 2'b10);
        n_tests++;
        if (state !== 3'd2 || p2_rounds !== 2'd0) begin
            n_fail++;
            $display("FAIL result_ignored_in_countdown: st=%0d p2=%0d, required 2,0", state, p2_rounds);
        end
        step(1'b1, 1'b0, 2'b11);
        n_tests++;
        if ({state, p1_rounds, p2_rounds} !== {3'd3, 2'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL double_ko: st=%0d p1=%0d p2=%0d, required 3,0,0", state, p1_rounds, p2_rounds);
        end
        ticks(60, 1'b0, 2'b00);
        n_tests++;
        if (state !== 3'd1 || countdown !== 2'd3) begin
            n_fail++;
            $display("FAIL double_ko_continue: st=%0d cd=%0d, required 1,3", state, countdown);
        end
    endtask

    task automatic test_abort();
        ticks(60, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b01);
        ticks(120, 1'b0, 2'b00);
        ticks(39, 1'b1, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        n_tests++;
        if (state !== 3'd2 || p1_rounds !== 2'd1) begin
            n_fail++;
            $display("FAIL hold39_release: st=%0d p1=%0d, required 2,1", state, p1_rounds);
        end
        ticks(39, 1'b1, 2'b00);
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL hold39_stays: st=%0d, required 2", state);
        end
        step(1'b1, 1'b1, 2'b00);
        n_tests++;
        if ({state, p1_rounds, p2_rounds, round_reset, input_enable} !== {3'd0, 2'd0, 2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL hold40_abort: st=%0d p1=%0d p2=%0d rr=%b ie=%b, required 0,0,0,1,0",
                     state, p1_rounds, p2_rounds, round_reset, input_enable);
        end
    endtask

    task automatic test_reset_mid_countdown();
        step(1'b1, 1'b1, 2'b00);
        ticks(60, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b10);
        ticks(70, 1'b0, 2'b00);
        n_tests++;
        if (state !== 3'd1 || p2_rounds !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset: st=%0d p2=%0d, required 1,1", state, p2_rounds);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({state, p2_rounds, round_reset, countdown} !== {3'd0, 2'd0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset: st=%0d p2=%0d rr=%b cd=%0d, required 0,0,1,0",
                     state, p2_rounds, round_reset, countdown);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 2'b10);
        n_tests++;
        if (state !== 3'd0 || p2_rounds !== 2'd0) begin
            n_fail++;
            $display("FAIL post_reset: st=%0d p2=%0d, required 0,0", state, p2_rounds);
        end
    endtask

    task automatic test_timer();
        health_1 = 9'd100; health_2 = 9'd80;
        step(1'b1, 1'b1, 2'b00);
        ticks(60, 1'b0, 2'b00);
`ifdef ROUND_TIMER_EN
        ticks(RT - 1, 1'b0, 2'b00);
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL timer_before_limit: st=%0d, required 2", state);
        end
        step(1'b1, 1'b0, 2'b00);
        n_tests++;
        if (state !== 3'd3 || p1_rounds !== 2'd1) begin
            n_fail++;
            $display("FAIL timer_health_win: st=%0d p1=%0d, required 3,1", state, p1_rounds);
        end
        ticks(120, 1'b0, 2'b00);
        ticks(RT - 1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b10);
        n_tests++;
        if ({state, p1_rounds, p2_rounds} !== {3'd3, 2'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL timer_ko_priority: st=%0d p1=%0d p2=%0d, required 3,1,1", state, p1_rounds, p2_rounds);
        end
`else
        ticks(RT + 100, 1'b0, 2'b00);
        n_tests++;
        if (state !== 3'd2 || p1_rounds !== 2'd0) begin
            n_fail++;
            $display("FAIL no_timer_fight_persists: st=%0d p1=%0d, required 2,0", state, p1_rounds);
        end
`endif
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        int burst;
        bit t, s;
        logic [1:0] rr;
        burst = 0;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                reset = 1'b1;
                model_reset();
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
            end else begin
                t = ($urandom_range(0, 3) != 0);
                if (burst > 0) begin
                    s = 1'b1;
                    burst--;
                end else if ($urandom_range(0, 299) == 0) begin
                    burst = $urandom_range(30, 80);
                    s = 1'b1;
                end else begin
                    s = ($urandom_range(0, 39) == 0);
                end
                rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                health_1 = 9'($urandom_range(0, 300));
                health_2 = 9'($urandom_range(0, 300));
                step(t, s, rr);
            end
            n_tests++;
            if ({state, p1_rounds, p2_rounds, countdown, match_winner, round_reset, input_enable}
                !== model_outputs()) begin
                n_fail++;
                $display("FAIL random_cycle %0d: dut st/p1/p2/cd/win/rr/ie=%b, model=%b",
                         i, {state, p1_rounds, p2_rounds, countdown, match_winner, round_reset, input_enable},
                         model_outputs());
            end
        end
    endtask

    initial begin
        reset = 1'b1; game_tick = 1'b0; start_btn = 1'b0; round_result = 2'b00;
        health_1 = 9'd0; health_2 = 9'd0;
        model_reset();
        test_reset();
        test_countdown();
        test_ko_match();
        test_double_ko();
        test_abort();
        test_reset_mid_countdown();
        test_timer();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
